// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
// PS/2 Set-2 scan-code decoder that tracks held/released state for a
// configurable set of keys. It understands the E0 extended prefix and the
// F0 break prefix, discards a prefix that waits too long for its next byte,
// and ignores controller response/error bytes.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   code_valid   one-cycle strobe, code_data valid this cycle
//   code_data    received scan-code byte
//   key_down     registered held state per key
//   key_press    one-cycle pulse on a 0->1 transition of key_down[i]
//   key_release  one-cycle pulse on a 1->0 transition of key_down[i]
//   any_key_down OR of key_down, registered alongside key_down
//   unknown_code one-cycle pulse for a make/break byte matching no key
module ps2_key_tracker #(
  parameter int NUM_KEYS = 4,
  // Packed NUM_KEYS*8 scan codes; key i occupies bits [8i+7:8i].
  parameter KEY_CODES = {8'h1E, 8'h16, 8'h5A, 8'h29},
  // Bit i set: key i matches only E0-prefixed; clear: only unprefixed.
  parameter logic [NUM_KEYS-1:0] KEY_EXT = '0,
  parameter int PREFIX_TIMEOUT = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                code_valid,
  input  logic [7:0]          code_data,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_key_down,
  output logic                unknown_code
);

  // Elaboration-time parameter sanity checks.
  generate
    if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_bad_num_keys
      $error("ps2_key_tracker: NUM_KEYS must be in 1..32");
    end
    if ($bits(KEY_CODES) != 8 * NUM_KEYS) begin : g_bad_key_codes
      $error("ps2_key_tracker: KEY_CODES must be 8*NUM_KEYS bits wide");
    end
    if (PREFIX_TIMEOUT < 2) begin : g_bad_timeout
      $error("ps2_key_tracker: PREFIX_TIMEOUT must be >= 2");
    end
  endgenerate

  localparam int TW = $clog2(PREFIX_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;

  logic [NUM_KEYS-1:0] key_down_reg, key_down_next;
  logic [NUM_KEYS-1:0] key_press_reg, key_press_next;
  logic [NUM_KEYS-1:0] key_release_reg, key_release_next;
  logic                any_key_down_reg, any_key_down_next;
  logic                unknown_code_reg, unknown_code_next;

  // Byte classification.
  logic is_e0, is_f0, is_resp, key_byte;
  logic ext, brk, timeout;
  logic [NUM_KEYS-1:0] match;

  assign is_e0 = (code_data == 8'hE0);
  assign is_f0 = (code_data == 8'hF0);

  always_comb begin
    is_resp = 1'b0;
    case (code_data)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_resp = 1'b1;
      default: is_resp = 1'b0;
    endcase
  end

  assign key_byte = code_valid && !is_e0 && !is_f0 && !is_resp;
  assign ext      = (state_reg == GOT_E0) || (state_reg == GOT_E0F0);
  assign brk      = (state_reg == GOT_F0) || (state_reg == GOT_E0F0);
  // A byte arriving on the timeout cycle takes priority over the timeout.
  assign timeout  = (state_reg != IDLE) && !code_valid && (timer_reg == TIMER_LAST);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
      assign match[gi] = (KEY_CODES[8*gi +: 8] == code_data) && (KEY_EXT[gi] == ext);
    end
  endgenerate

  // State register and prefix timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    if (code_valid) begin
      timer_next = '0;
      if (is_e0) begin
        state_next = GOT_E0;
      end else if (is_f0) begin
        case (state_reg)
          IDLE:    state_next = GOT_F0;
          GOT_E0:  state_next = GOT_E0F0;
          default: state_next = state_reg; // redundant F0 keeps the prefix
        endcase
      end else begin
        state_next = IDLE;
      end
    end else if (state_reg == IDLE || timeout) begin
      state_next = IDLE;
      timer_next = '0;
    end else begin
      timer_next = timer_reg + TW'(1);
    end
  end

  // Output next-value logic; pulses come from comparing old and new held state.
  always_comb begin
    key_down_next = key_down_reg;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_byte && match[i]) begin
        key_down_next[i] = !brk;
      end
    end
    key_press_next    = key_down_next & ~key_down_reg;
    key_release_next  = key_down_reg & ~key_down_next;
    any_key_down_next = |key_down_next;
    unknown_code_next = key_byte && (match == '0);
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_down_reg     <= '0;
      key_press_reg    <= '0;
      key_release_reg  <= '0;
      any_key_down_reg <= 1'b0;
      unknown_code_reg <= 1'b0;
    end else begin
      key_down_reg     <= key_down_next;
      key_press_reg    <= key_press_next;
      key_release_reg  <= key_release_next;
      any_key_down_reg <= any_key_down_next;
      unknown_code_reg <= unknown_code_next;
    end
  end

  assign key_down     = key_down_reg;
  assign key_press    = key_press_reg;
  assign key_release  = key_release_reg;
  assign any_key_down = any_key_down_reg;
  assign unknown_code = unknown_code_reg;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed testbench for ps2_key_tracker with a scoreboard.
// Keys: 0=29 space, 1=5A enter, 2=16 '1', 3=1E '2', 4=E0 14 (extended only).
// Each driven cycle pushes the expected outputs for the following cycle;
// a monitor pops and compares one entry per clock.
module tb_ps2_key_tracker;

  localparam int NK = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          code_valid = 1'b0;
  logic [7:0]    code_data = 8'h00;
  logic [NK-1:0] key_down, key_press, key_release;
  logic          any_key_down, unknown_code;

  ps2_key_tracker #(
    .NUM_KEYS(NK),
    .KEY_CODES({8'h14, 8'h1E, 8'h16, 8'h5A, 8'h29}),
    .KEY_EXT(5'b10000),
    .PREFIX_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .code_valid(code_valid),
    .code_data(code_data),
    .key_down(key_down),
    .key_press(key_press),
    .key_release(key_release),
    .any_key_down(any_key_down),
    .unknown_code(unknown_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] down;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic          any;
    logic          unk;
  } exp_t;

  exp_t          sb[$];
  logic [NK-1:0] prev_down = '0;
  int            vectors = 0;
  int            miscompares = 0;
  int            cycle = 0;

  function automatic exp_t make_exp(input logic [NK-1:0] down, input logic [NK-1:0] prev,
                                    input logic unk);
    exp_t e;
    e.down  = down;
    e.press = down & ~prev;
    e.rel   = prev & ~down;
    e.any   = |down;
    e.unk   = unk;
    return e;
  endfunction

  // One byte on one cycle; down is the hand-computed held state afterwards.
  task automatic send(input logic [7:0] b, input logic [NK-1:0] down, input logic unk);
    @(negedge clk);
    code_valid = 1'b1;
    code_data  = b;
    sb.push_back(make_exp(down, prev_down, unk));
    prev_down = down;
    $display("drive byte %02h exp_down=%05b exp_unk=%0d", b, down, unk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      code_valid = 1'b0;
      code_data  = 8'h00;
      sb.push_back(make_exp(prev_down, prev_down, 1'b0));
    end
  endtask

  // Reset pulse in mid-cycle; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    code_valid = 1'b0;
    sb.push_back(make_exp('0, '0, 1'b0));
    prev_down = '0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (key_down !== '0 || any_key_down !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: key_down=%05b any=%0d, required 00000 0", key_down, any_key_down);
    end else begin
      $display("check async_reset key_down=%05b ok", key_down);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: one scoreboard entry per clock, sampled after the edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a.down  = key_down;
        a.press = key_press;
        a.rel   = key_release;
        a.any   = any_key_down;
        a.unk   = unknown_code;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle %0d outputs: down=%05b press=%05b rel=%05b any=%0d unk=%0d, required down=%05b press=%05b rel=%05b any=%0d unk=%0d",
                   cycle, a.down, a.press, a.rel, a.any, a.unk, e.down, e.press, e.rel, e.any, e.unk);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({key_down, key_press, key_release, any_key_down, unknown_code} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: outputs=%b, required all zero",
               {key_down, key_press, key_release, any_key_down, unknown_code});
    end
    @(negedge clk);
    reset = 1'b0;

    // Make and break of space
    send(8'h29, 5'b00001, 1'b0);
    send(8'hF0, 5'b00001, 1'b0);
    send(8'h29, 5'b00000, 1'b0);
    // Back-to-back presses, then typematic repeat
    send(8'h5A, 5'b00010, 1'b0);
    send(8'h16, 5'b00110, 1'b0);
    send(8'h1E, 5'b01110, 1'b0);
    send(8'h5A, 5'b01110, 1'b0);
    idle(2);
    // Extended-only key: plain byte is unknown, E0-prefixed matches
    send(8'h14, 5'b01110, 1'b1);
    send(8'hE0, 5'b01110, 1'b0);
    send(8'h14, 5'b11110, 1'b0);
    // E0 F0 5A: enter is not extended, so this is unknown
    send(8'hE0, 5'b11110, 1'b0);
    send(8'hF0, 5'b11110, 1'b0);
    send(8'h5A, 5'b11110, 1'b1);
    // Extended break
    send(8'hE0, 5'b11110, 1'b0);
    send(8'hF0, 5'b11110, 1'b0);
    send(8'h14, 5'b01110, 1'b0);
    // Error byte cancels E0, following 14 is plain -> unknown
    send(8'hE0, 5'b01110, 1'b0);
    send(8'h00, 5'b01110, 1'b0);
    send(8'h14, 5'b01110, 1'b1);
    // E0 29 has no extended match
    send(8'hE0, 5'b01110, 1'b0);
    send(8'h29, 5'b01110, 1'b1);
    // Release remaining keys
    send(8'hF0, 5'b01110, 1'b0);
    send(8'h5A, 5'b01100, 1'b0);
    send(8'hF0, 5'b01100, 1'b0);
    send(8'h16, 5'b01000, 1'b0);
    send(8'hF0, 5'b01000, 1'b0);
    send(8'h1E, 5'b00000, 1'b0);
    // Timeout: 10 idle keeps F0 (silent break), 16 idle drops it (make),
    // 15 idle with byte on the timeout cycle keeps F0 (release)
    send(8'hF0, 5'b00000, 1'b0);
    idle(10);
    send(8'h29, 5'b00000, 1'b0);
    send(8'hF0, 5'b00000, 1'b0);
    idle(16);
    send(8'h29, 5'b00001, 1'b0);
    send(8'hF0, 5'b00001, 1'b0);
    idle(15);
    send(8'h29, 5'b00000, 1'b0);
    send(8'h29, 5'b00001, 1'b0);
    // Controller responses
    send(8'hAA, 5'b00001, 1'b0);
    send(8'hF0, 5'b00001, 1'b0);
    send(8'hFA, 5'b00001, 1'b0);
    send(8'h29, 5'b00001, 1'b0);
    // Redundant F0
    send(8'hF0, 5'b00001, 1'b0);
    send(8'hF0, 5'b00001, 1'b0);
    send(8'h29, 5'b00000, 1'b0);
    send(8'h29, 5'b00001, 1'b0);
    // Async reset between F0 and 29 discards the prefix
    send(8'hF0, 5'b00001, 1'b0);
    async_reset();
    send(8'h29, 5'b00001, 1'b0);
    idle(3);

    // Let the monitor drain, bounded by a cycle budget
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Clocked, parametrised PS/2 Set-2 scan-code decoder that keeps a held/released state for NUM_KEYS configurable keys. It handles the E0 extended prefix and the F0 break prefix, and gives one-cycle press and release pulses per key. It sits between the PS/2 byte receiver (one code_valid strobe per received byte) and the game/benchmark FSMs, and replaces the fixed four-key level-sensitive decoder.

Parameters:
NUM_KEYS, 4, number of tracked keys (1..32)
KEY_CODES, {8'h1E,8'h16,8'h5A,8'h29}, packed NUM_KEYS*8 scan codes; key i = bits [8i+7:8i] (default: i0=space 29, i1=enter 5A, i2='1' 16, i3='2' 1E)
KEY_EXT, 4'b0000, NUM_KEYS bitmask; bit i=1 means key i matches only when E0-prefixed, 0 means it matches only when not prefixed
PREFIX_TIMEOUT, 1_000_000, clk cycles a prefix state may wait for its next byte before it is discarded (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
code_valid  in  1  one-cycle strobe; code_data is valid this cycle
code_data  in  8  received scan-code byte
key_down  out  NUM_KEYS  registered held state per key
key_press  out  NUM_KEYS  one-cycle pulse on the 0->1 transition of key_down[i]
key_release  out  NUM_KEYS  one-cycle pulse on the 1->0 transition of key_down[i]
any_key_down  out  1  OR of key_down, registered in the same cycle as key_down
unknown_code  out  1  one-cycle pulse: a make/break byte that matched no key

Behaviour:
- Reset (async, any time): all outputs 0, FSM to IDLE, timeout counter 0. Reset mid-sequence discards any pending prefix.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. The FSM advances only on cycles with code_valid=1.
- 8'hE0 in any state -> GOT_E0.
- 8'hF0: IDLE->GOT_F0, GOT_E0->GOT_E0F0. In GOT_F0 or GOT_E0F0 the state is held (redundant prefix).
- 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF (controller responses/errors) in any state -> IDLE. No key update, no unknown_code.
- Any other byte b is a key byte and returns the FSM to IDLE:
  - ext = (state is GOT_E0 or GOT_E0F0); brk = (state is GOT_F0 or GOT_E0F0).
  - Every i with KEY_CODES[i]==b and KEY_EXT[i]==ext is updated: key_down[i] <= !brk.
  - If no i matches, unknown_code pulses.
- Latency: key_down, key_press, key_release, any_key_down and unknown_code all update on the clock edge that samples code_valid (visible the next cycle). Pulses last exactly one cycle.
- Typematic repeat (make while already down) leaves key_down at 1 with no key_press. Break while already up leaves it at 0 with no key_release. Both cases are silent, with no unknown_code.
- Duplicate entries in KEY_CODES: every matching key updates in the same cycle.
- Timeout: the counter increments each cycle the FSM is not IDLE and code_valid=0. It clears on every code_valid and in IDLE. When it reaches PREFIX_TIMEOUT-1 the FSM returns to IDLE, with no output change.
- code_valid on the timeout cycle: code_valid wins. The byte is processed in the current prefix state.
- No back-pressure; code_valid may assert on consecutive cycles, one byte per cycle.
- Parameter checks are elaboration-time only: NUM_KEYS range and KEY_CODES width = 8*NUM_KEYS.

Test Plan:
- Reset, then bytes 29 -> key_down=0001 and key_press=0001 for 1 cycle, any_key_down=1. Then F0,29 -> key_down=0000 and key_release=0001 for 1 cycle.
- Press 5A, 16, 1E on back-to-back cycles -> key_down=1110 one cycle after the last byte, with three separate single-bit key_press pulses. Then 5A again (repeat) -> no pulse, key_down unchanged.
- Set KEY_EXT=4'b0010, KEY_CODES[1]=8'h5A. Byte 5A -> unknown_code pulse, key_down[1]=0. Then E0,5A -> key_down[1]=1. Then E0,F0,5A -> key_down[1]=0 with a key_release[1] pulse.
- With PREFIX_TIMEOUT=16: F0, then 16 idle cycles, then 29 -> treated as a make, key_down[0]=1. With 10 idle cycles instead -> break, key_down[0] stays 0.
- Hold key 0 down, inject AA -> state unchanged, no pulses. Then F0, FA, 29 -> FA returns the FSM to IDLE, 29 is a make, key_down[0] stays 1 with no pulse.
- Assert reset asynchronously between F0 and 29 while key_down=0001 -> key_down=0 immediately. After release, 29 -> key_down=0001 with a key_press pulse.
